// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS control sequencer with memory wait states, run gating, illegal-opcode halt and counters
module mc_control_fsm #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic [5:0]           opcode,
   input  logic                 mem_ready,
   output logic                 PCWrite,
   output logic                 PCWriteCond,
   output logic                 IorD,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic                 MemtoReg,
   output logic                 IRWrite,
   output logic                 RegWrite,
   output logic                 RegDst,
   output logic                 ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ALUOp,
   output logic [1:0]           PCSource,
   output logic [3:0]           state,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] retired,
   output logic [CNT_WIDTH-1:0] cycles
);
   typedef enum logic [3:0] {
      FETCH      = 4'd0,
      DECODE     = 4'd1,
      MEM_ADDR   = 4'd2,
      MEM_READ   = 4'd3,
      MEM_WB     = 4'd4,
      MEM_WRITE  = 4'd5,
      EXECUTE    = 4'd6,
      R_COMPLETE = 4'd7,
      BRANCH     = 4'd8,
      JUMP       = 4'd9,
      ADDI_EXEC  = 4'd10,
      ADDI_WB    = 4'd11,
      HALT       = 4'd12
   } state_t;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   state_t               state_q, state_d;
   logic                 retire;
   logic [CNT_WIDTH-1:0] retired_q, cycles_q;
   assign state   = state_q;
   assign halted  = state_q >= HALT;
   assign retired = retired_q;
   assign cycles  = cycles_q;
   // state register and counters; reset wins over any pending transition or retire
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FETCH;
         retired_q <= '0;
         cycles_q  <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_q + CNT_WIDTH'(retire);
         cycles_q  <= cycles_q + CNT_WIDTH'(1);
      end
   end
   // Moore decode of the state (FETCH also looks at run/mem_ready) and next-state selection
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      retire      = 1'b0;
      state_d     = state_q;
      case (state_q)
         FETCH: if (run) begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            state_d = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            ALUSrcB = 2'b11;
            state_d = opcode == OP_R                      ? EXECUTE   :
                      (opcode == OP_LW || opcode == OP_SW) ? MEM_ADDR  :
                      opcode == OP_BEQ                    ? BRANCH    :
                      opcode == OP_J                      ? JUMP      :
                      opcode == OP_ADDI                   ? ADDI_EXEC : HALT;
         end
         MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = opcode == OP_LW ? MEM_READ : opcode == OP_SW ? MEM_WRITE : HALT;
         end
         MEM_READ: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
            state_d = mem_ready ? MEM_WB : MEM_READ;
         end
         MEM_WB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
            retire   = 1'b1;
            state_d  = FETCH;
         end
         MEM_WRITE: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
            retire   = mem_ready;
            state_d  = mem_ready ? FETCH : MEM_WRITE;
         end
         EXECUTE: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
            state_d = R_COMPLETE;
         end
         R_COMPLETE: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
            retire   = 1'b1;
            state_d  = FETCH;
         end
         BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            retire      = 1'b1;
            state_d     = FETCH;
         end
         JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            retire   = 1'b1;
            state_d  = FETCH;
         end
         ADDI_EXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = ADDI_WB;
         end
         ADDI_WB: begin
            RegWrite = 1'b1;
            retire   = 1'b1;
            state_d  = FETCH;
         end
         default: state_d = HALT;
      endcase
   end
endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle control sequencer for the MIPS datapath: a Moore state machine that decodes the opcode held in the instruction register and issues per-cycle strobes (PC, instruction register, memory, register file, ALU muxes) so that one shared ALU and one unified memory execute R-type, lw, sw, beq, j and addi over several cycles. It sits beside `mipsProcessor` as the replacement for the single-cycle `UC`. It adds a memory wait-state handshake, a run/hold input, an illegal-opcode halt and retired-instruction/cycle counters for the testbench.

## Interface
- `CNT_WIDTH`, 32, width of `retired` and `cycles` counters
- `clk` in 1: single clock, all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `run` in 1: permits a new fetch; sampled only in FETCH
- `opcode` in 6: instruction[31:26] from the instruction register, valid from DECODE onward
- `mem_ready` in 1: memory completes the current access this cycle
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA` out 1: datapath strobes
- `ALUSrcB` out 2: 00 = reg B, 01 = const 4, 10 = signext imm, 11 = signext imm << 2
- `ALUOp` out 2: 00 = add, 01 = sub, 10 = funct-decoded
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `state` out 4: current state encoding (debug)
- `halted` out 1: FSM is in HALT
- `retired` out CNT_WIDTH: instructions completed
- `cycles` out CNT_WIDTH: clocks since reset

## Operation
- State encodings:
  - 0 FETCH, 1 DECODE, 2 MEM_ADDR, 3 MEM_READ, 4 MEM_WB, 5 MEM_WRITE
  - 6 EXECUTE, 7 R_COMPLETE, 8 BRANCH, 9 JUMP, 10 ADDI_EXEC, 11 ADDI_WB, 12 HALT
  - 13–15 unused; treated as HALT.
- Strobes not listed below are 0 in that state.
- FETCH:
  - If `run`=0: no strobes; hold.
  - Else: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=`mem_ready`.
  - Go to DECODE on `mem_ready`=1, else hold.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - 000000 → EXECUTE
  - 100011 / 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDI_EXEC
  - anything else → HALT
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: lw → MEM_READ, sw → MEM_WRITE; the opcode is re-sampled here.
- MEM_READ: MemRead=1, IorD=1. Hold until `mem_ready`, then MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1 → FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Hold until `mem_ready`, then FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → R_COMPLETE.
- R_COMPLETE: RegDst=1, MemtoReg=0, RegWrite=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 → FETCH.
- JUMP: PCWrite=1, PCSource=10 → FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → ADDI_WB.
- ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1 → FETCH.
- HALT: all strobes 0, `halted`=1. Leaves only on `reset`.
- `retired` increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, R_COMPLETE, BRANCH, JUMP or ADDI_WB. Branch-not-taken still counts.
- `cycles` increments every non-reset clock, including in HALT.
- Both counters wrap modulo 2^CNT_WIDTH.

## Timing
- Reset (sampled at the rising edge):
  - state=FETCH, `retired`=0, `cycles`=0, `halted`=0.
  - Outputs then follow FETCH decode: with `run`=0, all strobes 0.
- Reset mid-instruction overrides any transition. Strobes of the aborted state drop in the cycle after the edge. No partial retire count.
- Outputs are pure decode of the state register (plus `mem_ready`/`run` in FETCH, and `mem_ready` for IRWrite/PCWrite). No output registers.
- Latency with `mem_ready` tied 1:
  - lw 5 cycles
  - sw, R-type, addi 4 cycles
  - beq, j 3 cycles
- Each cycle `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. Strobes are held stable during the wait.
- `run` falling mid-instruction does not stop it; the FSM parks at the next FETCH.

## Test plan
- **R-type add:** `run`=1, `mem_ready`=1, opcode 000000 → states 0,1,6,7,0. RegWrite=1, RegDst=1 only in cycle 4. `retired`=1 after cycle 4.
- **lw with wait states:** `mem_ready` low for 2 cycles in MEM_READ → states 0,1,2,3,3,3,4. Total 7 cycles; MemtoReg=1 in MEM_WB; `retired`=1.
- **sw, beq, j back-to-back:** zero-wait memory → 4+3+3=10 cycles, `retired`=3. MemWrite high exactly 1 cycle; PCWriteCond high only in BRANCH; PCSource=10 in JUMP.
- **Illegal opcode 111111:** → HALT at cycle 3, `halted`=1, all strobes 0 for 20 cycles. `cycles` keeps counting; `retired` unchanged. Reset returns to FETCH with `halted`=0.
- **run gating:** `run`=0 after reset for 5 cycles → state 0, MemRead=0, `cycles`=5, `retired`=0. Raising `run` → MemRead=1 the same cycle.
- **Reset mid-MEM_WRITE:** with `mem_ready`=0, assert `reset` → MemWrite=0 the next cycle, state=0, both counters 0.
